// File: rtl/instr_fetch_unit_pkg.sv
// ifu_pkg: shared types and helpers for the instruction fetch front end.
//   state_t     - fetch FSM states (IDLE / FETCH / FAULT)
//   entry_t     - prefetch queue entry {pc, instr}
//   ROM_BYTES   - ROM size in bytes for the default ROM address width
//   rom_bytes_f - ROM size in bytes for any ROM word-address width
//   target_legal- true when a fetch target is word aligned and inside the ROM
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam int DEF_ADDR_W = 6;

    // 33 bits so that a ROM filling the whole 32-bit space still compares correctly
    function automatic logic [32:0] rom_bytes_f(input int addr_w);
        rom_bytes_f = 33'd4 << addr_w;
    endfunction

    localparam logic [32:0] ROM_BYTES = rom_bytes_f(DEF_ADDR_W);

    function automatic logic target_legal(input logic [31:0] tgt, input logic [32:0] rom_bytes);
        target_legal = (tgt[1:0] == 2'b00) && ({1'b0, tgt} < rom_bytes);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus bundle between the fetch unit, the instruction ROM,
// the decode stage and the execute-stage redirect source.
//   rom_addr/rom_dout          - combinational ROM read port
//   id_valid/id_ready          - decode handshake, id_instr/id_pc carry the head entry
//   redirect_valid/redirect_pc - branch/jump target from execute
//   fault/fault_pc             - fetch halted on an illegal target
// master = fetch unit side, slave = environment side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_dout;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [31:0]       id_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              fault;
    logic [31:0]       fault_pc;

    modport master (
        output rom_addr,
        input  rom_dout,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        input  redirect_valid,
        input  redirect_pc,
        output fault,
        output fault_pc
    );

    modport slave (
        input  rom_addr,
        output rom_dout,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        output redirect_valid,
        output redirect_pc,
        input  fault,
        input  fault_pc
    );
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries.
//   push/din  - write an entry (accepted when not full, or full with a same-cycle pop)
//   pop       - drop the head entry (ignored when empty)
//   flush     - empty the queue; overrides push and pop
//   full/empty- occupancy flags
//   head      - head entry, reads as zero while the queue is empty
module fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t din,
    output logic   full,
    output logic   empty,
    output entry_t head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == DEPTH_CNT);
    assign head  = empty ? '0 : mem_r[rd_ptr_r];

    // Qualify requests: a full queue still takes a push when the head leaves the same cycle
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_pop_s  = pop && !empty;
            do_push_s = push && (!full || do_pop_s);
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only visible through head while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch front end.
// Owns the PC, reads the combinational ROM at pc[ADDR_W+1:2], queues {pc, instr}
// entries and presents them to decode through a valid/ready handshake.
// Redirects flush the queue and reload the PC; illegal targets or running off the
// end of the ROM halt fetching with fault/fault_pc until a legal redirect arrives.
// Ports: clk, rst (synchronous, active high), bus (instr_fetch_unit_if.master).
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 6,
    parameter int          DEPTH    = 2
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    localparam logic [32:0] ROM_BYTES_L = rom_bytes_f(ADDR_W);

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_s;
    logic        fault_r;
    logic        fault_next_s;
    logic [31:0] fault_pc_r;
    logic [31:0] fault_pc_next_s;
    logic        push_s;
    logic        pop_s;
    logic        flush_s;
    logic        full_s;
    logic        empty_s;
    entry_t      din_s;
    entry_t      head_s;

    assign pc_plus4_s   = pc_r + 32'd4;
    assign din_s        = '{pc: pc_r, instr: bus.rom_dout};
    assign bus.rom_addr = pc_r[ADDR_W+1:2];
    assign bus.id_valid = !empty_s;
    assign bus.id_instr = head_s.instr;
    assign bus.id_pc    = head_s.pc;
    assign bus.fault    = fault_r;
    assign bus.fault_pc = fault_pc_r;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   (din_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // Next-state, PC and queue control; a redirect overrides everything else
    always_comb begin
        next_state_s    = state_r;
        pc_next_s       = pc_r;
        fault_pc_next_s = fault_pc_r;
        push_s          = 1'b0;
        pop_s           = !empty_s && bus.id_ready;
        flush_s         = 1'b0;
        if (bus.redirect_valid) begin
            flush_s   = 1'b1;
            pop_s     = 1'b0;
            pc_next_s = bus.redirect_pc;
            if (target_legal(bus.redirect_pc, ROM_BYTES_L)) begin
                next_state_s = FETCH;
            end else begin
                next_state_s    = FAULT;
                fault_pc_next_s = bus.redirect_pc;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    next_state_s = FETCH;
                end
                FETCH: begin
                    if (!full_s || pop_s) begin
                        push_s    = 1'b1;
                        pc_next_s = pc_plus4_s;
                        // The last ROM word is still queued; the following fetch would leave the ROM
                        if ({1'b0, pc_plus4_s} == ROM_BYTES_L) begin
                            next_state_s    = FAULT;
                            fault_pc_next_s = pc_plus4_s;
                        end else begin
                            next_state_s = FETCH;
                        end
                    end else begin
                        next_state_s = FETCH;
                    end
                end
                FAULT: begin
                    next_state_s = FAULT;
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
        fault_next_s = (next_state_s == FAULT);
    end

    // FSM, PC and fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            fault_r    <= 1'b0;
            fault_pc_r <= 32'h0000_0000;
        end else begin
            state_r    <= next_state_s;
            pc_r       <= pc_next_s;
            fault_r    <= fault_next_s;
            fault_pc_r <= fault_pc_next_s;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2;

    typedef struct {
        logic [31:0] tgt;
        logic        exp_fault;
        logic [31:0] exp_fault_pc;
        logic        exp_valid;
        logic [31:0] exp_instr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] rom [64];
    logic [31:0] exp_q [$];
    logic [31:0] sb_exp;
    vec_t        tbl [10];
    int          tests = 0;
    int          failed = 0;
    int          pop_cnt = 0;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.rom_dout       = rom[bus.rom_addr];
    assign bus.id_ready       = id_ready;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic legal(input logic [31:0] t);
        return (t[1:0] == 2'b00) && (t < 32'd256);
    endfunction

    task automatic push_stream(input logic [31:0] from);
        for (logic [31:0] p = from; p <= 32'h0000_00FC; p += 32'd4) exp_q.push_back(p);
    endtask

    // Scoreboard: every accepted head must be the next expected PC and its ROM word
    always @(negedge clk) begin
        if (!rst && !redirect_valid && bus.id_valid && id_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL sb_unexpected: got pc %h, expected no entry", bus.id_pc);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_pc", bus.id_pc, sb_exp);
                check("sb_instr", bus.id_instr, rom[sb_exp[7:2]]);
            end
        end
    end

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_q.delete();
        if (legal(tgt)) push_stream(tgt);
        step(1);
        redirect_valid = 1'b0;
    endtask

    // Reset for ncyc edges, check reset values, then release and check startup timing
    task automatic do_start(input int ncyc);
        rst = 1'b1;
        exp_q.delete();
        step(ncyc);
        check("rst_id_valid", {31'h0, bus.id_valid}, 32'h0);
        check("rst_id_instr", bus.id_instr, 32'h0);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst_fault", {31'h0, bus.fault}, 32'h0);
        check("rst_fault_pc", bus.fault_pc, 32'h0);
        check("rst_rom_addr", {26'h0, bus.rom_addr}, 32'h0);
        id_ready = 1'b1;
        rst = 1'b0;
        push_stream(32'h0);
        step(1);
        check("c1_id_valid", {31'h0, bus.id_valid}, 32'h0);
        check("c1_rom_addr", {26'h0, bus.rom_addr}, 32'h0);
        step(1);
        check("c2_id_valid", {31'h0, bus.id_valid}, 32'h1);
        check("c2_id_pc", bus.id_pc, 32'h0);
        check("c2_id_instr", bus.id_instr, 32'h00003f37);
        step(1);
        check("c3_id_pc", bus.id_pc, 32'h4);
        check("c3_id_instr", bus.id_instr, 32'h02000fe7);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] ra0;
        logic [31:0] tmp;
        int          c0;

        for (int i = 0; i < 64; i++) rom[i] = 32'h1300_0000 | i;
        rom[0] = 32'h00003f37;
        rom[1] = 32'h02000fe7;
        rom[2] = 32'h01c02623;
        rom[8] = 32'h00001c63;

        tbl[0] = '{32'h0000_0020, 1'b0, 32'h0,         1'b1, 32'h00001c63};
        tbl[1] = '{32'h0000_0022, 1'b1, 32'h0000_0022, 1'b0, 32'h0};
        tbl[2] = '{32'h0000_0008, 1'b0, 32'h0,         1'b1, 32'h01c02623};
        tbl[3] = '{32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
        tbl[4] = '{32'h0000_0040, 1'b0, 32'h0,         1'b1, 32'h13000010};
        tbl[5] = '{32'h0000_0007, 1'b1, 32'h0000_0007, 1'b0, 32'h0};
        tbl[6] = '{32'h0000_0010, 1'b0, 32'h0,         1'b1, 32'h13000004};
        tbl[7] = '{32'h0000_00FC, 1'b1, 32'h0000_0100, 1'b1, 32'h1300003F};
        tbl[8] = '{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        tbl[9] = '{32'h0000_0000, 1'b0, 32'h0,         1'b1, 32'h00003f37};

        do_start(2);

        // Throughput: one instruction per cycle with id_ready high
        c0 = pop_cnt;
        step(10);
        check("throughput", pop_cnt - c0, 32'd10);

        // Redirect table
        for (int i = 0; i < 10; i++) begin
            do_redirect(tbl[i].tgt);
            check("rdr_n1_id_valid", {31'h0, bus.id_valid}, 32'h0);
            step(1);
            check("rdr_fault", {31'h0, bus.fault}, {31'h0, tbl[i].exp_fault});
            if (tbl[i].exp_fault) check("rdr_fault_pc", bus.fault_pc, tbl[i].exp_fault_pc);
            check("rdr_id_valid", {31'h0, bus.id_valid}, {31'h0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                check("rdr_id_pc", bus.id_pc, tbl[i].tgt);
                check("rdr_id_instr", bus.id_instr, tbl[i].exp_instr);
            end
            step(1);
            if (tbl[i].exp_fault) begin
                check("fault_id_valid", {31'h0, bus.id_valid}, 32'h0);
                check("fault_drained", exp_q.size(), 32'd0);
            end
            step(2);
        end

        // Backpressure: stall 5 cycles, queue fills and PC freezes
        do_redirect(32'h0000_0040);
        step(3);
        id_ready = 1'b0;
        step(2);
        ra0 = {26'h0, bus.rom_addr};
        step(3);
        check("bp_rom_addr_frozen", {26'h0, bus.rom_addr}, ra0);
        check("bp_id_valid", {31'h0, bus.id_valid}, 32'h1);
        tmp = bus.id_pc + 32'd4 * DEPTH;
        check("bp_queue_full", {26'h0, bus.rom_addr}, {26'h0, tmp[7:2]});
        id_ready = 1'b1;
        c0 = pop_cnt;
        step(8);
        check("bp_resume", pop_cnt - c0, 32'd8);

        // Full queue and fault, then a single-cycle reset and restart
        id_ready = 1'b0;
        do_redirect(32'h0000_00F8);
        step(2);
        check("ff_fault", {31'h0, bus.fault}, 32'h1);
        check("ff_fault_pc", bus.fault_pc, 32'h0000_0100);
        check("ff_id_pc", bus.id_pc, 32'h0000_00F8);
        do_start(1);
        step(4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
